a2d_intf: RTL and testbench
===========================

A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 Parameter SCLK_DIV_W, default 5, is the SPI clock-divider counter width (SCLK period = 2^SCLK_DIV_W clk cycles).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 nxt  input  1  single-cycle pulse requesting conversion of the next channel in the round-robin.
REQ-005 MISO  input  1  serial data from the A2D converter.
REQ-006 SS_n  output  1  active-low slave select to the A2D.
REQ-007 SCLK  output  1  SPI serial clock; idles high.
REQ-008 MOSI  output  1  serial command data to the A2D.
REQ-009 lft_ld  output  12  left load-cell reading (channel 0).
REQ-010 rght_ld  output  12  right load-cell reading (channel 4).
REQ-011 steer_pot  output  12  steering potentiometer reading (channel 5).
REQ-012 batt  output  12  battery voltage reading (channel 6).

Function
REQ-013 The block SHALL service channels in the fixed order 0, 4, 5, 6, then wrap to 0, advancing one position per completed conversion.
REQ-014 A conversion SHALL consist of two 16-bit SPI transactions: CMD sends {2'b00, chnl[2:0], 11'h000}; READ sends 16'h0000 and captures the response.
REQ-015 The FSM SHALL have states IDLE, CMD, GAP and READ: IDLE->CMD on nxt; CMD->GAP on SPI done; GAP->READ after exactly one cycle; READ->IDLE on SPI done.
REQ-016 nxt SHALL be ignored in every state except IDLE; the ignored pulse is neither queued nor counted.
REQ-017 On READ done, the output register for the current channel SHALL load rd_data[11:0] on the next clock edge; the upper 4 bits are discarded; the other three registers SHALL hold.
REQ-018 The round-robin pointer SHALL advance on the same edge that updates the output register.
REQ-019 nxt arriving in the same cycle the FSM returns to IDLE SHALL be ignored; nxt is accepted only when sampled while the FSM is in IDLE.
REQ-020 SPI: SS_n SHALL fall the cycle after the write request; exactly 16 SCLK periods per transaction; MOSI changes on SCLK falling edges, MSB first; MISO is sampled on SCLK rising edges.
REQ-021 SPI done SHALL pulse for one cycle, and SS_n SHALL return high on that same cycle, no later than 17*2^SCLK_DIV_W clk cycles after the write request.
REQ-022 SS_n SHALL stay high in IDLE and GAP, and for at least one clk cycle between CMD and READ.

Reset
REQ-023 On rst_n low: FSM to IDLE; pointer to channel 0; lft_ld, rght_ld, steer_pot and batt to 12'h000; SS_n=1; SCLK=1; MOSI=0.
REQ-024 Reset asserted mid-transaction SHALL abort it immediately (SS_n high asynchronously) without updating any output register.

Configuration
REQ-025 With macro A2D_LD_FILT_EN defined, lft_ld and rght_ld SHALL each load (previous + new)>>1, computed with a 13-bit sum; steer_pot and batt are unaffected.
REQ-026 Without A2D_LD_FILT_EN, every output SHALL load the raw 12-bit conversion result.

Structure
REQ-027 Package a2d_pkg SHALL hold the channel-code constants (0, 4, 5, 6) and the FSM state typedef.
REQ-028 The SPI engine SHALL be a separate sub-module spi_mnrch with ports clk, rst_n, wrt, wt_data[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI and MISO.

Verification
REQ-029 After reset, with the A2D model returning 12'hABC: one nxt -> MOSI command 16'h0000 in CMD, then lft_ld=12'hABC; the other three outputs remain 12'h000.
REQ-030 Four nxt pulses, each issued after the previous conversion completes, with the model returning 12'h111, 12'h222, 12'h333, 12'h444 -> lft_ld=111, rght_ld=222, steer_pot=333, batt=444; command channel fields 0, 4, 5, 6.
REQ-031 A fifth nxt -> command channel field 0 again (wrap); only lft_ld changes.
REQ-032 Pulse nxt during CMD and during READ -> no extra conversion; the pointer advances only once.
REQ-033 Assert rst_n low at SCLK period 8 of READ -> SS_n=1 at once, all outputs 12'h000, and the next nxt converts channel 0.
REQ-034 With A2D_LD_FILT_EN defined, lft_ld conversions of 12'h100 then 12'h300 -> lft_ld=12'h080 after the first conversion, then 12'h1C0 after the second.

Source files
------------

// File: rtl/a2d_pkg.sv
// a2d_pkg: channel codes, FSM state type and round-robin helper for a2d_intf.
// rev 1.0
`default_nettype none

package a2d_pkg;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    GAP  = 2'd2,
    READ = 2'd3
  } state_t;

  // Round-robin slot (0..3) to A2D channel code.
  function automatic logic [2:0] chnl_code(input logic [1:0] idx);
    case (idx)
      2'd0:    chnl_code = CH_LFT;
      2'd1:    chnl_code = CH_RGHT;
      2'd2:    chnl_code = CH_STEER;
      default: chnl_code = CH_BATT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mnrch.sv
// spi_mnrch: 16-bit SPI master, SCLK idles high, MOSI shifts on SCLK fall, MISO sampled on rise.
// rev 1.0
`default_nettype none

module spi_mnrch #(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  // SCLK is the divider MSB: starting at 10..0 gives a half-period front porch;
  // each wrap from all-ones to zero is a falling edge.
  localparam logic [SCLK_DIV_W-1:0] DIV_LAST     = '1;
  localparam logic [SCLK_DIV_W-1:0] DIV_START    = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_PRE_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

  logic [SCLK_DIV_W-1:0] div_q, div_d;
  logic [15:0]           tx_q, tx_d;
  logic [15:0]           rx_q, rx_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  ss_n_q, ss_n_d;
  logic                  done_q, done_d;

  always_comb begin
    div_d  = div_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    cnt_d  = cnt_q;
    ss_n_d = ss_n_q;
    done_d = 1'b0;
    if (ss_n_q) begin
      if (wrt) begin
        ss_n_d = 1'b0;
        div_d  = DIV_START;
        tx_d   = wt_data;
        cnt_d  = 5'd0;
      end
    end else begin
      div_d = div_q + 1'b1;
      if (div_q == DIV_PRE_RISE) begin
        rx_d  = {rx_q[14:0], MISO};
        cnt_d = cnt_q + 5'd1;
      end
      if (div_q == DIV_LAST) begin
        if (cnt_q == 5'd16) begin
          ss_n_d = 1'b1;
          done_d = 1'b1;
          div_d  = DIV_LAST;
          tx_d   = '0;
        end else if (cnt_q != 5'd0) begin
          // The first fall precedes any rise, so the MSB is already on MOSI.
          tx_d = {tx_q[14:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DIV_LAST;
      tx_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
      ss_n_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      ss_n_q <= ss_n_d;
      done_q <= done_d;
    end
  end

  assign done    = done_q;
  assign rd_data = rx_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = div_q[SCLK_DIV_W-1];
  assign MOSI    = tx_q[15];

endmodule

`default_nettype wire

// File: rtl/a2d_intf.sv
// a2d_intf: round-robin A2D reader (channels 0,4,5,6) over SPI.
// rev 1.0 -- option: A2D_LD_FILT_EN averages new load-cell readings with the previous ones.
`default_nettype none

module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt
);

  state_t      state_q, state_d;
  logic        wrt_q, wrt_d;
  logic [15:0] wt_data_q, wt_data_d;
  logic [1:0]  idx_q, idx_d;
  logic [11:0] lft_ld_q, lft_ld_d, rght_ld_q, rght_ld_d;
  logic [11:0] steer_pot_q, steer_pot_d, batt_q, batt_d;

  logic        done;
  logic [15:0] rd_data;
  logic [11:0] rd12;
  logic [3:0]  unused_rd_hi;
  logic [11:0] lft_new, rght_new;

  assign rd12         = rd_data[11:0];
  assign unused_rd_hi = rd_data[15:12];

`ifdef A2D_LD_FILT_EN
  assign lft_new  = 12'(({1'b0, lft_ld_q}  + {1'b0, rd12}) >> 1);
  assign rght_new = 12'(({1'b0, rght_ld_q} + {1'b0, rd12}) >> 1);
`else
  assign lft_new  = rd12;
  assign rght_new = rd12;
`endif

  always_comb begin
    state_d     = state_q;
    wrt_d       = 1'b0;
    wt_data_d   = wt_data_q;
    idx_d       = idx_q;
    lft_ld_d    = lft_ld_q;
    rght_ld_d   = rght_ld_q;
    steer_pot_d = steer_pot_q;
    batt_d      = batt_q;
    case (state_q)
      IDLE: if (nxt) begin
        state_d   = CMD;
        wrt_d     = 1'b1;
        wt_data_d = {2'b00, chnl_code(idx_q), 11'h000};
      end
      CMD: if (done) state_d = GAP;
      GAP: begin
        state_d   = READ;
        wrt_d     = 1'b1;
        wt_data_d = 16'h0000;
      end
      READ: if (done) begin
        state_d = IDLE;
        idx_d   = idx_q + 2'd1;
        case (idx_q)
          2'd0:    lft_ld_d    = lft_new;
          2'd1:    rght_ld_d   = rght_new;
          2'd2:    steer_pot_d = rd12;
          default: batt_d      = rd12;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wrt_q       <= 1'b0;
      wt_data_q   <= '0;
      idx_q       <= '0;
      lft_ld_q    <= '0;
      rght_ld_q   <= '0;
      steer_pot_q <= '0;
      batt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wrt_q       <= wrt_d;
      wt_data_q   <= wt_data_d;
      idx_q       <= idx_d;
      lft_ld_q    <= lft_ld_d;
      rght_ld_q   <= rght_ld_d;
      steer_pot_q <= steer_pot_d;
      batt_q      <= batt_d;
    end
  end

  spi_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt_q),
    .wt_data (wt_data_q),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  assign lft_ld    = lft_ld_q;
  assign rght_ld   = rght_ld_q;
  assign steer_pot = steer_pot_q;
  assign batt      = batt_q;

endmodule

`default_nettype wire

// File: tb/tb_a2d_intf.sv
// tb_a2d_intf: directed bench for a2d_intf with a behavioural SPI A2D model.
// rev 1.0
`default_nettype none

module tb_a2d_intf;

  localparam int DW = 5;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt   = 1'b0;
  logic        MISO  = 1'b0;
  wire         SS_n, SCLK, MOSI;
  wire  [11:0] lft_ld, rght_ld, steer_pot, batt;

  always #5 clk = ~clk;

  a2d_intf #(.SCLK_DIV_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .MISO      (MISO),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // A2D model: upper nibble is non-zero so truncation to 12 bits is exercised.
  logic [11:0] a2d_val = 12'h000;
  logic [15:0] m_tx = '0, m_rx = '0;
  int          m_bits = 0;
  bit          in_txn = 1'b0;
  int          n_fall = 0, n_done = 0;
  logic [15:0] cmd_log [0:63];

  always @(negedge SS_n) begin
    in_txn = 1'b1;
    n_fall++;
    m_bits = 0;
    m_rx   = '0;
    m_tx   = {4'hA, a2d_val};
    MISO   = m_tx[15];
  end

  always @(posedge SCLK) if (in_txn) begin
    m_rx = {m_rx[14:0], MOSI};
    m_bits++;
  end

  always @(negedge SCLK) if (in_txn && m_bits > 0 && m_bits < 16) begin
    m_tx = {m_tx[14:0], 1'b0};
    MISO = m_tx[15];
  end

  always @(posedge SS_n) if (in_txn) begin
    in_txn = 1'b0;
    cmd_log[n_done & 63] = m_rx;
    n_done++;
  end

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] ld_exp(input logic [11:0] prev, input logic [11:0] nw);
`ifdef A2D_LD_FILT_EN
    logic [12:0] s;
    s = {1'b0, prev} + {1'b0, nw};
    return s[12:1];
`else
    return nw;
`endif
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_done = 0;
    n_fall = 0;
  endtask

  task automatic pulse_nxt();
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 3000 && n_done < target; k++) @(negedge clk);
    check("conv_timeout", 16'(n_done >= target), 16'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_fall(input int target);
    for (int k = 0; k < 3000 && n_fall < target; k++) @(negedge clk);
    check("ss_fall_timeout", 16'(n_fall >= target), 16'd1);
  endtask

  task automatic convert(input logic [11:0] val, output logic [15:0] cmd);
    int base;
    base    = n_done;
    a2d_val = val;
    pulse_nxt();
    wait_done(base + 2);
    cmd = cmd_log[base & 63];
  endtask

  logic [15:0] cmd;
  logic [11:0] e_lft, e_rght, e_steer, e_batt;
  logic [11:0] rr_val [4] = '{12'h111, 12'h222, 12'h333, 12'h444};
  logic [2:0]  rr_ch  [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
  int          f0;

  initial begin
    do_reset();
    check("rst_ss_n", 16'(SS_n), 16'd1);
    check("rst_sclk", 16'(SCLK), 16'd1);
    check("rst_mosi", 16'(MOSI), 16'd0);
    check("rst_lft",   16'(lft_ld),    16'h000);
    check("rst_rght",  16'(rght_ld),   16'h000);
    check("rst_steer", 16'(steer_pot), 16'h000);
    check("rst_batt",  16'(batt),      16'h000);

    // Single conversion from reset
    convert(12'hABC, cmd);
    check("first_cmd",  cmd, 16'h0000);
    check("first_lft",  16'(lft_ld),    16'(ld_exp(12'h000, 12'hABC)));
    check("first_rght", 16'(rght_ld),   16'h000);
    check("first_steer",16'(steer_pot), 16'h000);
    check("first_batt", 16'(batt),      16'h000);
    check("first_txns", 16'(n_done),    16'd2);

    // Full round robin
    do_reset();
    for (int i = 0; i < 4; i++) begin
      convert(rr_val[i], cmd);
      check($sformatf("rr_cmd%0d", i), cmd, {2'b00, rr_ch[i], 11'h000});
    end
    e_lft   = ld_exp(12'h000, 12'h111);
    e_rght  = ld_exp(12'h000, 12'h222);
    e_steer = 12'h333;
    e_batt  = 12'h444;
    check("rr_lft",   16'(lft_ld),    16'(e_lft));
    check("rr_rght",  16'(rght_ld),   16'(e_rght));
    check("rr_steer", 16'(steer_pot), 16'(e_steer));
    check("rr_batt",  16'(batt),      16'(e_batt));

    // Wrap back to channel 0
    convert(12'h555, cmd);
    e_lft = ld_exp(e_lft, 12'h555);
    check("wrap_cmd",   cmd, 16'h0000);
    check("wrap_lft",   16'(lft_ld),    16'(e_lft));
    check("wrap_rght",  16'(rght_ld),   16'(e_rght));
    check("wrap_steer", 16'(steer_pot), 16'(e_steer));
    check("wrap_batt",  16'(batt),      16'(e_batt));

    // nxt pulses during CMD and READ are ignored
    f0      = n_fall;
    a2d_val = 12'h666;
    pulse_nxt();
    wait_fall(f0 + 1);
    repeat (100) @(negedge clk);
    pulse_nxt();
    wait_fall(f0 + 2);
    repeat (100) @(negedge clk);
    pulse_nxt();
    wait_done(f0 + 2);
    repeat (1500) @(negedge clk);
    e_rght = ld_exp(e_rght, 12'h666);
    check("busy_nxt_txns", 16'(n_fall), 16'(f0 + 2));
    check("busy_rght",     16'(rght_ld), 16'(e_rght));
    convert(12'h777, cmd);
    check("busy_next_cmd", cmd, 16'h2800);
    check("busy_steer",    16'(steer_pot), 16'h777);

    // nxt in the cycle the FSM returns to IDLE is ignored
    f0      = n_fall;
    a2d_val = 12'h888;
    pulse_nxt();
    for (int k = 0; k < 3000 && n_done < f0 + 2; k++) begin
      @(posedge clk);
      #1;
    end
    nxt = 1'b1;
    @(posedge clk);
    #1;
    nxt = 1'b0;
    repeat (1500) @(negedge clk);
    check("done_nxt_txns", 16'(n_fall), 16'(f0 + 2));
    check("done_batt",     16'(batt),   16'h888);

    // Reset in the middle of READ
    f0      = n_fall;
    a2d_val = 12'h999;
    pulse_nxt();
    wait_fall(f0 + 2);
    for (int k = 0; k < 1000 && m_bits < 8; k++) @(negedge clk);
    check("abort_reached", 16'(m_bits >= 8), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ss_n",  16'(SS_n),      16'd1);
    check("abort_sclk",  16'(SCLK),      16'd1);
    check("abort_lft",   16'(lft_ld),    16'h000);
    check("abort_rght",  16'(rght_ld),   16'h000);
    check("abort_steer", 16'(steer_pot), 16'h000);
    check("abort_batt",  16'(batt),      16'h000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_done = 0;
    n_fall = 0;
    convert(12'h5A5, cmd);
    check("post_abort_cmd", cmd, 16'h0000);
    check("post_abort_lft", 16'(lft_ld), 16'(ld_exp(12'h000, 12'h5A5)));

`ifdef A2D_LD_FILT_EN
    do_reset();
    convert(12'h100, cmd);
    check("filt_lft1", 16'(lft_ld), 16'h080);
    for (int i = 1; i < 4; i++) convert(12'h000, cmd);
    convert(12'h300, cmd);
    check("filt_lft2", 16'(lft_ld), 16'h1C0);
    check("filt_steer", 16'(steer_pot), 16'h000);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
